hdlc_rx_drain: RTL and testbench
================================

# hdlc_rx_drain

Receive-side bus master sitting directly downstream of the Hdlc controller's register interface. When Hdlc raises Rx_Ready, the block reads Rx status and length, then drains the Rx buffer byte by byte into a valid/ready byte stream with end-of-frame marking. Errored, aborted, overflowed or malformed frames are discarded via the Rx_Drop command. The block also keeps good-frame and bad-frame counters.

## Interface
- MAX_LEN, 126: largest accepted payload length in bytes. Rx_Len of 0 or above MAX_LEN is a bad frame.
- Clk  in  1  system clock; all logic rising-edge.
- Rst  in  1  asynchronous, active-high reset.
- Rx_Ready  in  1  Hdlc frame-ready flag.
- Address  out  3  Hdlc register address. 2 = Rx_SC, 3 = Rx_Buff, 4 = Rx_Len.
- WriteEnable  out  1  single-cycle register write strobe.
- ReadEnable  out  1  single-cycle register read strobe.
- DataIn  out  8  write data to Hdlc.
- DataOut  in  8  read data from Hdlc; valid the cycle after ReadEnable.
- M_Data  out  8  stream byte.
- M_Valid  out  1  stream byte valid.
- M_Ready  in  1  consumer accepts byte when M_Valid & M_Ready.
- M_Last  out  1  marks final byte of frame; qualified by M_Valid.
- Frames_Ok  out  16  delivered-frame count, saturating.
- Frames_Bad  out  16  dropped-frame count, saturating.
- Busy  out  1  high whenever state is not IDLE.

## Operation
- Rx_SC bits: 0 Rx_Ready, 1 Rx_Drop (write), 2 Rx_FrameError, 3 Rx_AbortSignal, 4 Rx_Overflow.
- IDLE: if Rx_Ready=1, go to SC_REQ.
- SC_REQ: Address=2, ReadEnable=1, go to SC_WAIT.
- SC_WAIT: sample DataOut.
  - Any of bits 2/3/4 set: go to DROP.
  - Bit 0 clear: go to IDLE (spurious; no count).
  - Otherwise: go to LEN_REQ.
- LEN_REQ: Address=4, ReadEnable=1, go to LEN_WAIT.
- LEN_WAIT: sample length.
  - 0 or >MAX_LEN: go to DROP.
  - Otherwise: load 7-bit remaining counter Cnt=length, go to DAT_REQ.
- DAT_REQ: issue Address=3, ReadEnable=1 only if the output slot is free (M_Valid=0, or M_Valid & M_Ready this cycle); otherwise hold. Then go to DAT_WAIT.
- DAT_WAIT: M_Data<=DataOut, M_Valid<=1, M_Last<=(Cnt==1), Cnt<=Cnt-1.
  - Cnt==1: go to DONE.
  - Otherwise: go to DAT_REQ.
- DONE: wait until M_Valid=0 and Rx_Ready=0, then increment Frames_Ok and go to IDLE.
- DROP: Address=2, WriteEnable=1, DataIn=8'h02 for one cycle; increment Frames_Bad; go to CLR_WAIT.
- CLR_WAIT: wait for Rx_Ready=0, then go to IDLE.
- Address, DataIn: 0 whenever no strobe is active. Only one strobe (ReadEnable or WriteEnable) per cycle, never both.
- Output register: M_Valid clears on handshake unless reloaded the same cycle. M_Data/M_Last stable while M_Valid & !M_Ready.
- Counters saturate at 16'hFFFF, never wrap.
- Rx_Ready changes outside IDLE/DONE/CLR_WAIT are ignored.

## Timing
- Reset (async assert, sync release): state IDLE. All outputs 0, Cnt=0, counters 0.
- Rx_Ready rise to first Rx_SC ReadEnable: 1 cycle.
- Rx_SC read to first Rx_Buff ReadEnable: 4 cycles (SC_REQ, SC_WAIT, LEN_REQ, LEN_WAIT).
- Rx_Buff ReadEnable to M_Valid high: 2 cycles.
- Peak throughput with M_Ready held high: 1 byte per 2 cycles. An N-byte frame occupies 4+2N cycles from SC_REQ to DONE.
- Backpressure: DAT_REQ issues no ReadEnable while the slot is full; no byte is lost or duplicated.
- Reset mid-frame: M_Valid drops at once with no M_Last. No write is issued to Hdlc.
- Length exactly MAX_LEN is accepted; MAX_LEN+1 is dropped.

## Test plan
- Good frame: Rx_SC=8'h01, Rx_Len=3, buffer A5 3C 7E, M_Ready=1.
  - Stream A5,3C,7E with M_Last only on 7E.
  - Exactly 3 Rx_Buff reads; Frames_Ok=1.
- Backpressure: same frame with M_Ready low for 5 cycles after the first byte.
  - M_Data holds A5; no Rx_Buff read while stalled.
  - Full sequence delivered intact.
- Error frame: Rx_SC=8'h05 (FrameError).
  - No Rx_Len/Rx_Buff reads.
  - One write Address=2, DataIn=02.
  - Frames_Bad=1, no stream output.
- Length bounds:
  - Rx_Len=0: dropped.
  - Rx_Len=127 (MAX_LEN=126): dropped.
  - Rx_Len=126: 126 bytes streamed, last flagged.
- Reset mid-frame: assert Rst during the 2nd byte.
  - Outputs 0 immediately.
  - Next Rx_Ready frame of 2 bytes processed normally; Frames_Ok=1.
- Saturation: force 65536 bad frames (or preload). Frames_Bad stays FFFF.

Source files
------------

// File: rtl/hdlc_rx_drain.sv
// Hdlc receive drain: reads Rx status/length, streams the Rx buffer out as
// valid/ready bytes, discards bad frames and counts good and bad frames.
module hdlc_rx_drain #(
    parameter int MAX_LEN = 126
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Rx_Ready,
    output logic [2:0]  Address,
    output logic        WriteEnable,
    output logic        ReadEnable,
    output logic [7:0]  DataIn,
    input  logic [7:0]  DataOut,
    output logic [7:0]  M_Data,
    output logic        M_Valid,
    input  logic        M_Ready,
    output logic        M_Last,
    output logic [15:0] Frames_Ok,
    output logic [15:0] Frames_Bad,
    output logic        Busy
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] SC_REQ   = 4'd1;
    localparam logic [3:0] SC_WAIT  = 4'd2;
    localparam logic [3:0] LEN_REQ  = 4'd3;
    localparam logic [3:0] LEN_WAIT = 4'd4;
    localparam logic [3:0] DAT_REQ  = 4'd5;
    localparam logic [3:0] DAT_WAIT = 4'd6;
    localparam logic [3:0] DONE     = 4'd7;
    localparam logic [3:0] DROP     = 4'd8;
    localparam logic [3:0] CLR_WAIT = 4'd9;

    localparam logic [2:0] ADDR_SC   = 3'd2;
    localparam logic [2:0] ADDR_BUFF = 3'd3;
    localparam logic [2:0] ADDR_LEN  = 3'd4;
    localparam logic [7:0] MAX_B     = 8'(MAX_LEN);

    logic [3:0] state;
    logic [6:0] cnt;
    logic       slot_free;

    // A byte may be fetched only if the output register will be empty.
    assign slot_free = !M_Valid || M_Ready;
    assign Busy      = (state != IDLE);

    always_comb begin
        Address     = 3'd0;
        ReadEnable  = 1'b0;
        WriteEnable = 1'b0;
        DataIn      = 8'h00;
        case (state)
            SC_REQ: begin
                Address    = ADDR_SC;
                ReadEnable = 1'b1;
            end
            LEN_REQ: begin
                Address    = ADDR_LEN;
                ReadEnable = 1'b1;
            end
            DAT_REQ: begin
                if (slot_free) begin
                    Address    = ADDR_BUFF;
                    ReadEnable = 1'b1;
                end
            end
            DROP: begin
                Address     = ADDR_SC;
                WriteEnable = 1'b1;
                DataIn      = 8'h02;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            cnt        <= 7'd0;
            M_Data     <= 8'h00;
            M_Valid    <= 1'b0;
            M_Last     <= 1'b0;
            Frames_Ok  <= 16'h0000;
            Frames_Bad <= 16'h0000;
        end else begin
            if (M_Valid && M_Ready)
                M_Valid <= 1'b0;
            case (state)
                IDLE:
                    if (Rx_Ready)
                        state <= SC_REQ;
                SC_REQ:
                    state <= SC_WAIT;
                SC_WAIT:
                    if (|DataOut[4:2])
                        state <= DROP;
                    else if (!DataOut[0])
                        state <= IDLE;
                    else
                        state <= LEN_REQ;
                LEN_REQ:
                    state <= LEN_WAIT;
                LEN_WAIT:
                    if (DataOut == 8'd0 || DataOut > MAX_B) begin
                        state <= DROP;
                    end else begin
                        cnt   <= DataOut[6:0];
                        state <= DAT_REQ;
                    end
                DAT_REQ:
                    if (slot_free)
                        state <= DAT_WAIT;
                DAT_WAIT: begin
                    M_Data  <= DataOut;
                    M_Valid <= 1'b1;
                    M_Last  <= (cnt == 7'd1);
                    cnt     <= cnt - 7'd1;
                    state   <= (cnt == 7'd1) ? DONE : DAT_REQ;
                end
                DONE:
                    if (!M_Valid && !Rx_Ready) begin
                        if (Frames_Ok != 16'hFFFF)
                            Frames_Ok <= Frames_Ok + 16'd1;
                        state <= IDLE;
                    end
                DROP: begin
                    if (Frames_Bad != 16'hFFFF)
                        Frames_Bad <= Frames_Bad + 16'd1;
                    state <= CLR_WAIT;
                end
                CLR_WAIT:
                    if (!Rx_Ready)
                        state <= IDLE;
                default:
                    state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hdlc_rx_drain.sv
// Bench for hdlc_rx_drain: behavioural Hdlc register model, stream
// scoreboard queues and one task per scenario.
module tb_hdlc_rx_drain;

    logic        clk;
    logic        rst;
    logic        rx_ready;
    logic [2:0]  address;
    logic        write_en;
    logic        read_en;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic [15:0] frames_ok;
    logic [15:0] frames_bad;
    logic        busy;

    hdlc_rx_drain #(.MAX_LEN(126)) dut (
        .Clk(clk),
        .Rst(rst),
        .Rx_Ready(rx_ready),
        .Address(address),
        .WriteEnable(write_en),
        .ReadEnable(read_en),
        .DataIn(data_in),
        .DataOut(data_out),
        .M_Data(m_data),
        .M_Valid(m_valid),
        .M_Ready(m_ready),
        .M_Last(m_last),
        .Frames_Ok(frames_ok),
        .Frames_Bad(frames_bad),
        .Busy(busy)
    );

    int checks = 0;
    int passed = 0;

    // Hdlc model state
    int         arm_id = 0;
    int         done_id = 0;
    logic [7:0] frame_sc;
    logic [7:0] frame_len;
    logic [7:0] mem [256];
    int         rd_idx = 0;
    int         rd_sc = 0;
    int         rd_len = 0;
    int         rd_buf = 0;
    int         wr_cnt = 0;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_data = 8'h00;
    int         viol = 0;

    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];

    assign rx_ready = (arm_id != done_id);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            done_id <= arm_id;
        end else begin
            if (read_en) begin
                case (address)
                    3'd2: begin
                        data_out <= frame_sc;
                        rd_sc    <= rd_sc + 1;
                        rd_idx   <= 0;
                    end
                    3'd4: begin
                        data_out <= frame_len;
                        rd_len   <= rd_len + 1;
                    end
                    3'd3: begin
                        data_out <= mem[rd_idx];
                        rd_buf   <= rd_buf + 1;
                        rd_idx   <= rd_idx + 1;
                        if (rd_idx + 1 >= int'(frame_len))
                            done_id <= arm_id;
                    end
                    default: data_out <= 8'h00;
                endcase
            end
            if (write_en) begin
                wr_cnt  <= wr_cnt + 1;
                wr_addr <= address;
                wr_data <= data_in;
                if (address == 3'd2 && data_in[1])
                    done_id <= arm_id;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid && m_ready)
            obs_q.push_back({m_last, m_data});
        if (read_en && write_en)
            viol++;
        if (!read_en && !write_en && (address != 3'd0 || data_in != 8'h00))
            viol++;
    end

    task automatic arm(input logic [7:0] sc, input logic [7:0] len,
                       input bit good);
        frame_sc  = sc;
        frame_len = len;
        if (good)
            for (int i = 0; i < int'(len); i++)
                exp_q.push_back({(i == int'(len) - 1), mem[i]});
        arm_id++;
    endtask

    task automatic drain(output bit to);
        to = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy && !rx_ready) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_valid, m_last, m_data, read_en, write_en, address, data_in, busy} !== 23'd0)
            $display("FAIL reset_outputs: got %h want 0",
                     {m_valid, m_last, m_data, read_en, write_en, address, data_in, busy});
        else passed++;
        checks++;
        if ({frames_ok, frames_bad} !== 32'd0)
            $display("FAIL reset_counters: got %h want 0", {frames_ok, frames_bad});
        else passed++;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_idle: got %b want 0", busy);
        else passed++;
    endtask

    task automatic test_good;
        int b0, l0, w0;
        bit to;
        b0 = rd_buf; l0 = rd_len; w0 = wr_cnt;
        mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h7E;
        @(posedge clk); #1 m_ready = 1'b1;
        arm(8'h01, 8'd3, 1'b1);
        @(negedge clk);
        checks++;
        if (read_en !== 1'b0) $display("FAIL good_no_early_read: got %b want 0", read_en);
        else passed++;
        @(negedge clk);
        checks++;
        if ({read_en, address} !== 4'b1_010)
            $display("FAIL good_sc_read: got %b want 1010", {read_en, address});
        else passed++;
        repeat (4) @(negedge clk);
        checks++;
        if ({read_en, address} !== 4'b1_011)
            $display("FAIL good_first_buff: got %b want 1011", {read_en, address});
        else passed++;
        repeat (2) @(negedge clk);
        checks++;
        if ({m_valid, m_data} !== 9'h1A5)
            $display("FAIL good_first_byte: got %h want 1a5", {m_valid, m_data});
        else passed++;
        drain(to);
        checks++;
        if (to) $display("FAIL good_timeout: got timeout want idle");
        else passed++;
        checks++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL good_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            logic [8:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) $display("FAIL good_byte: got %h want %h", o, e);
            else passed++;
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if ({rd_buf - b0, rd_len - l0, wr_cnt - w0} !== {32'd3, 32'd1, 32'd0})
            $display("FAIL good_reads: got buf %0d len %0d wr %0d want 3 1 0",
                     rd_buf - b0, rd_len - l0, wr_cnt - w0);
        else passed++;
        checks++;
        if (frames_ok !== 16'd1) $display("FAIL good_frames_ok: got %0d want 1", frames_ok);
        else passed++;
    endtask

    task automatic test_backpressure;
        int b0;
        bit to;
        bit seen;
        mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h7E;
        @(posedge clk); #1 m_ready = 1'b0;
        arm(8'h01, 8'd3, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = m_valid;
        end
        checks++;
        if (!seen) $display("FAIL bp_first_valid: got no valid want valid");
        else passed++;
        b0 = rd_buf;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({m_valid, m_data, rd_buf - b0} !== {1'b1, 8'hA5, 32'd0})
                $display("FAIL bp_hold: got v %b d %h reads %0d want 1 a5 0",
                         m_valid, m_data, rd_buf - b0);
            else passed++;
        end
        @(posedge clk); #1 m_ready = 1'b1;
        drain(to);
        checks++;
        if (to) $display("FAIL bp_timeout: got timeout want idle");
        else passed++;
        checks++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            logic [8:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) $display("FAIL bp_byte: got %h want %h", o, e);
            else passed++;
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (frames_ok !== 16'd2) $display("FAIL bp_frames_ok: got %0d want 2", frames_ok);
        else passed++;
    endtask

    task automatic test_error;
        int b0, l0, w0;
        bit to;
        b0 = rd_buf; l0 = rd_len; w0 = wr_cnt;
        @(posedge clk); #1;
        arm(8'h05, 8'd3, 1'b0);
        drain(to);
        checks++;
        if (to) $display("FAIL err_timeout: got timeout want idle");
        else passed++;
        checks++;
        if ({rd_buf - b0, rd_len - l0, wr_cnt - w0} !== {32'd0, 32'd0, 32'd1})
            $display("FAIL err_access: got buf %0d len %0d wr %0d want 0 0 1",
                     rd_buf - b0, rd_len - l0, wr_cnt - w0);
        else passed++;
        checks++;
        if ({wr_addr, wr_data} !== {3'd2, 8'h02})
            $display("FAIL err_write: got %0d %h want 2 02", wr_addr, wr_data);
        else passed++;
        checks++;
        if (frames_bad !== 16'd1) $display("FAIL err_frames_bad: got %0d want 1", frames_bad);
        else passed++;
        checks++;
        if (obs_q.size() !== 0) $display("FAIL err_stream: got %0d bytes want 0", obs_q.size());
        else passed++;
        obs_q.delete();
    endtask

    task automatic test_len_bounds;
        int b0;
        bit to;
        logic [7:0] bad_len [2];
        bad_len[0] = 8'd0; bad_len[1] = 8'd127;
        for (int k = 0; k < 2; k++) begin
            b0 = rd_buf;
            @(posedge clk); #1;
            arm(8'h01, bad_len[k], 1'b0);
            drain(to);
            checks++;
            if ({to, rd_buf - b0, obs_q.size()} !== {1'b0, 32'd0, 32'd0})
                $display("FAIL len_drop_%0d: got to %b reads %0d bytes %0d want 0 0 0",
                         bad_len[k], to, rd_buf - b0, obs_q.size());
            else passed++;
            checks++;
            if (frames_bad !== 16'(k + 2))
                $display("FAIL len_bad_cnt: got %0d want %0d", frames_bad, k + 2);
            else passed++;
            obs_q.delete();
        end
        for (int i = 0; i < 126; i++) mem[i] = 8'(i * 37 + 11);
        @(posedge clk); #1;
        arm(8'h01, 8'd126, 1'b1);
        drain(to);
        checks++;
        if (to) $display("FAIL len_max_timeout: got timeout want idle");
        else passed++;
        checks++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL len_max_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            logic [8:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) $display("FAIL len_max_byte: got %h want %h", o, e);
            else passed++;
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (frames_ok !== 16'd3) $display("FAIL len_max_ok: got %0d want 3", frames_ok);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int w0;
        bit to;
        bit seen;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        w0 = wr_cnt;
        @(posedge clk); #1 m_ready = 1'b1;
        arm(8'h01, 8'd3, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = m_valid && (m_data == 8'h22);
        end
        checks++;
        if (!seen) $display("FAIL rst_mid_second: got no 2nd byte want 22");
        else passed++;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({m_valid, m_last, read_en, write_en, busy, frames_ok} !== 21'd0)
            $display("FAIL rst_mid_outputs: got %h want 0",
                     {m_valid, m_last, read_en, write_en, busy, frames_ok});
        else passed++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (wr_cnt - w0 !== 0) $display("FAIL rst_mid_write: got %0d want 0", wr_cnt - w0);
        else passed++;
        exp_q.delete(); obs_q.delete();
        mem[0] = 8'hC3; mem[1] = 8'h5A;
        @(posedge clk); #1;
        arm(8'h01, 8'd2, 1'b1);
        drain(to);
        checks++;
        if (to) $display("FAIL rst_mid_timeout: got timeout want idle");
        else passed++;
        checks++;
        if (obs_q.size() !== exp_q.size())
            $display("FAIL rst_mid_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            logic [8:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) $display("FAIL rst_mid_byte: got %h want %h", o, e);
            else passed++;
        end
        exp_q.delete(); obs_q.delete();
        checks++;
        if (frames_ok !== 16'd1) $display("FAIL rst_mid_ok: got %0d want 1", frames_ok);
        else passed++;
    endtask

    task automatic test_saturation;
        bit to;
        logic [15:0] want [3];
        want[0] = 16'hFFFE; want[1] = 16'hFFFF; want[2] = 16'hFFFF;
        @(negedge clk);
        force dut.Frames_Bad = 16'hFFFD;
        @(negedge clk);
        release dut.Frames_Bad;
        @(negedge clk);
        checks++;
        if (frames_bad !== 16'hFFFD) $display("FAIL sat_preload: got %h want fffd", frames_bad);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            arm(8'h11, 8'd3, 1'b0);
            drain(to);
            checks++;
            if ({to, frames_bad} !== {1'b0, want[k]})
                $display("FAIL sat_step%0d: got to %b bad %h want 0 %h",
                         k, to, frames_bad, want[k]);
            else passed++;
        end
    endtask

    task automatic test_protocol;
        checks++;
        if (viol !== 0) $display("FAIL strobe_protocol: got %0d violations want 0", viol);
        else passed++;
    endtask

    initial begin
        rst     = 1'b1;
        m_ready = 1'b1;
        test_reset;
        test_good;
        test_backpressure;
        test_error;
        test_len_bounds;
        test_reset_mid;
        test_saturation;
        test_protocol;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
